// File: rtl/cus19_pkg.sv
// Shared definitions for the Custom19 store path: data widths, drain FSM
// encoding and the layout of one store-buffer entry {wide, addr, data}.
package cus19_pkg;

    localparam int CUS19_REG_W = 16;
    localparam int CUS19_DM_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BYTE0 = 2'd1,
        ST_BYTE1 = 2'd2
    } st_state_e;

    // Width of one packed store entry {wide, addr[addr_w-1:0], data[15:0]}.
    function automatic int cus19_entry_w(input int addr_w);
        return 1 + addr_w + CUS19_REG_W;
    endfunction

endpackage

// File: rtl/cus19_store_fifo.sv
// Store buffer: DEPTH-entry circular FIFO. Exposes the head entry for the
// drain FSM and every slot plus its valid bit for the load-hazard compare.
module cus19_store_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head_data,
    output logic [$clog2(DEPTH)-1:0]      head_ptr,
    output logic [DEPTH*WIDTH-1:0]        entries,
    output logic [DEPTH-1:0]              valid,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          full,
    output logic                          empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] off;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == {CNT_W{1'b0}});
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];
    assign head_ptr  = rd_ptr;

    // Entry storage; contents are only meaningful where valid is set.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= {PTR_W{1'b0}};
            rd_ptr <= {PTR_W{1'b0}};
            count  <= {CNT_W{1'b0}};
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1'b1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1'b1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Flatten slots and mark a slot valid when its distance from head < count.
    always_comb begin
        entries = {DEPTH*WIDTH{1'b0}};
        valid   = {DEPTH{1'b0}};
        off     = {PTR_W{1'b0}};
        for (int j = 0; j < DEPTH; j++) begin
            entries[j*WIDTH +: WIDTH] = mem[j];
            off      = PTR_W'(j) - rd_ptr;
            valid[j] = (CNT_W'(off) < count);
        end
    end

endmodule

// File: rtl/cus19_store_unit.sv
// Custom19 store unit: buffers ST requests and drains them one byte per
// handshake to the data memory (low byte first, then high byte for wide
// stores), and flags loads that hit a byte still waiting in the buffer.
module cus19_store_unit
    import cus19_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_valid_in,
    input  logic [ADDR_W-1:0]      st_addr_in,
    input  logic [CUS19_REG_W-1:0] st_data_in,
    input  logic                   st_wide_in,
    output logic                   st_stall_out,
    output logic                   st_busy_out,
    output logic                   dm_wr_en_out,
    output logic [ADDR_W-1:0]      dm_wr_addr_out,
    output logic [CUS19_DM_W-1:0]  dm_wr_data_out,
    input  logic                   dm_wr_ready_in,
    input  logic [ADDR_W-1:0]      ld_addr_in,
    output logic                   ld_hazard_out
);

    localparam int ENTRY_W = cus19_entry_w(ADDR_W);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH+1);

    typedef struct packed {
        logic                   wide;
        logic [ADDR_W-1:0]      addr;
        logic [CUS19_REG_W-1:0] data;
    } entry_t;

    st_state_e            state;
    entry_t               push_entry;
    entry_t               head;
    entry_t               slot;
    logic [DEPTH*ENTRY_W-1:0] entries;
    logic [DEPTH-1:0]     valid;
    logic [PTR_W-1:0]     head_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_after;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 lo_pending;

    cus19_store_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head),
        .head_ptr  (head_ptr),
        .entries   (entries),
        .valid     (valid),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Accept a request only when the buffer had room at the start of the cycle.
    always_comb begin
        push_entry = '{wide: st_wide_in, addr: st_addr_in, data: st_data_in};
        push       = st_valid_in && !full;
        if (state == ST_BYTE1) begin
            pop = dm_wr_ready_in;
        end else if (state == ST_BYTE0) begin
            pop = dm_wr_ready_in && !head.wide;
        end else begin
            pop = 1'b0;
        end
        count_after = count + CNT_W'(push) - CNT_W'(pop);
    end

    // Drain FSM: IDLE waits for an entry, BYTE0/BYTE1 write low/high byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (count != {CNT_W{1'b0}}) state <= ST_BYTE0;
                end
                ST_BYTE0: begin
                    if (dm_wr_ready_in) begin
                        if (head.wide)                          state <= ST_BYTE1;
                        else if (count_after != {CNT_W{1'b0}})  state <= ST_BYTE0;
                        else                                    state <= ST_IDLE;
                    end
                end
                ST_BYTE1: begin
                    if (dm_wr_ready_in) begin
                        if (count_after != {CNT_W{1'b0}}) state <= ST_BYTE0;
                        else                              state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory write port decoded from FSM state and the buffer head only.
    always_comb begin
        st_stall_out = full;
        st_busy_out  = !empty;
        case (state)
            ST_BYTE0: begin
                dm_wr_en_out   = 1'b1;
                dm_wr_addr_out = head.addr;
                dm_wr_data_out = head.data[7:0];
            end
            ST_BYTE1: begin
                dm_wr_en_out   = 1'b1;
                dm_wr_addr_out = head.addr + ADDR_W'(1'b1);
                dm_wr_data_out = head.data[15:8];
            end
            default: begin
                dm_wr_en_out   = 1'b0;
                dm_wr_addr_out = {ADDR_W{1'b0}};
                dm_wr_data_out = {CUS19_DM_W{1'b0}};
            end
        endcase
    end

    // Load hazard: any pending byte of any valid entry matches the load address.
    // The head's low byte is already written once the FSM is in BYTE1.
    always_comb begin
        ld_hazard_out = 1'b0;
        slot          = '0;
        lo_pending    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            slot       = entry_t'(entries[i*ENTRY_W +: ENTRY_W]);
            lo_pending = !((PTR_W'(i) == head_ptr) && (state == ST_BYTE1));
            if (valid[i]) begin
                if ((lo_pending && (slot.addr == ld_addr_in)) ||
                    (slot.wide && ((slot.addr + ADDR_W'(1'b1)) == ld_addr_in))) begin
                    ld_hazard_out = 1'b1;
                end else begin
                    ld_hazard_out = ld_hazard_out;
                end
            end else begin
                ld_hazard_out = ld_hazard_out;
            end
        end
    end

endmodule

// File: tb/tb_cus19_store_unit.sv
// Directed bench for cus19_store_unit: expected memory writes are queued as
// stores are driven and compared when the DUT performs a write handshake.
module tb_cus19_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid_in;
    logic [9:0]  st_addr_in;
    logic [15:0] st_data_in;
    logic        st_wide_in;
    logic        st_stall_out;
    logic        st_busy_out;
    logic        dm_wr_en_out;
    logic [9:0]  dm_wr_addr_out;
    logic [7:0]  dm_wr_data_out;
    logic        dm_wr_ready_in;
    logic [9:0]  ld_addr_in;
    logic        ld_hazard_out;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  xfers  = 0;
    int  x0;

    cus19_store_unit #(.ADDR_W(10), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .st_valid_in    (st_valid_in),
        .st_addr_in     (st_addr_in),
        .st_data_in     (st_data_in),
        .st_wide_in     (st_wide_in),
        .st_stall_out   (st_stall_out),
        .st_busy_out    (st_busy_out),
        .dm_wr_en_out   (dm_wr_en_out),
        .dm_wr_addr_out (dm_wr_addr_out),
        .dm_wr_data_out (dm_wr_data_out),
        .dm_wr_ready_in (dm_wr_ready_in),
        .ld_addr_in     (ld_addr_in),
        .ld_hazard_out  (ld_hazard_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a store request; queue the bytes it should produce if accepted.
    task automatic drive_store(input logic [9:0] a, input logic [15:0] d,
                               input logic w, input logic accepted);
        st_valid_in = 1'b1;
        st_addr_in  = a;
        st_data_in  = d;
        st_wide_in  = w;
        if (accepted) begin
            exp_q.push_back('{addr: a, data: d[7:0]});
            if (w) exp_q.push_back('{addr: a + 10'd1, data: d[15:8]});
        end
    endtask

    // Scoreboard: a write handshake seen mid-cycle completes on the next edge.
    always @(negedge clk) begin
        if (!rst && dm_wr_en_out && dm_wr_ready_in) begin
            wr_t e;
            xfers++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write observed=%0h/%0h expected=none",
                       dm_wr_addr_out, dm_wr_data_out);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_addr", 32'(dm_wr_addr_out), 32'(e.addr));
                check("sb_data", 32'(dm_wr_data_out), 32'(e.data));
            end
        end
    end

    initial begin
        rst = 1'b1; st_valid_in = 1'b0; st_addr_in = 10'd0; st_data_in = 16'd0;
        st_wide_in = 1'b0; dm_wr_ready_in = 1'b0; ld_addr_in = 10'd0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_stall", 32'(st_stall_out), 32'd0);
        check("rst_busy",  32'(st_busy_out),  32'd0);
        check("rst_en",    32'(dm_wr_en_out), 32'd0);
        check("rst_addr",  32'(dm_wr_addr_out), 32'd0);
        check("rst_data",  32'(dm_wr_data_out), 32'd0);
        check("rst_haz",   32'(ld_hazard_out), 32'd0);

        // Narrow store with ready high
        dm_wr_ready_in = 1'b1;
        x0 = xfers;
        drive_store(10'h010, 16'hBEEF, 1'b0, 1'b1);
        tick();
        st_valid_in = 1'b0;
        check("n_busy", 32'(st_busy_out), 32'd1);
        check("n_en_lat", 32'(dm_wr_en_out), 32'd0);
        tick();
        check("n_en", 32'(dm_wr_en_out), 32'd1);
        check("n_addr", 32'(dm_wr_addr_out), 32'h010);
        check("n_data", 32'(dm_wr_data_out), 32'hEF);
        tick();
        check("n_en_done", 32'(dm_wr_en_out), 32'd0);
        check("n_busy_done", 32'(st_busy_out), 32'd0);
        check("n_count", 32'(xfers - x0), 32'd1);

        // Wide store held under backpressure
        dm_wr_ready_in = 1'b0;
        x0 = xfers;
        drive_store(10'h020, 16'h1234, 1'b1, 1'b1);
        tick();
        st_valid_in = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("w_hold_en",   32'(dm_wr_en_out), 32'd1);
            check("w_hold_addr", 32'(dm_wr_addr_out), 32'h020);
            check("w_hold_data", 32'(dm_wr_data_out), 32'h34);
            tick();
        end
        dm_wr_ready_in = 1'b1;
        tick();
        check("w_b1_addr", 32'(dm_wr_addr_out), 32'h021);
        check("w_b1_data", 32'(dm_wr_data_out), 32'h12);
        tick();
        check("w_idle_en", 32'(dm_wr_en_out), 32'd0);
        check("w_busy", 32'(st_busy_out), 32'd0);
        check("w_count", 32'(xfers - x0), 32'd2);

        // Load hazard against a pending wide store
        dm_wr_ready_in = 1'b0;
        drive_store(10'h040, 16'hABCD, 1'b1, 1'b1);
        tick();
        st_valid_in = 1'b0;
        ld_addr_in = 10'h041; #1; check("hz_hi", 32'(ld_hazard_out), 32'd1);
        ld_addr_in = 10'h042; #1; check("hz_miss", 32'(ld_hazard_out), 32'd0);
        ld_addr_in = 10'h040; #1; check("hz_lo", 32'(ld_hazard_out), 32'd1);
        tick();
        dm_wr_ready_in = 1'b1;
        tick();
        ld_addr_in = 10'h040; #1; check("hz_lo_done", 32'(ld_hazard_out), 32'd0);
        ld_addr_in = 10'h041; #1; check("hz_hi_b1", 32'(ld_hazard_out), 32'd1);
        tick();
        check("hz_hi_done", 32'(ld_hazard_out), 32'd0);
        ld_addr_in = 10'h000;

        // Address wrap on wide store at the top of memory
        drive_store(10'h3FF, 16'h5A6B, 1'b1, 1'b1);
        tick();
        st_valid_in = 1'b0;
        tick();
        check("wr_b0_addr", 32'(dm_wr_addr_out), 32'h3FF);
        tick();
        check("wr_b1_addr", 32'(dm_wr_addr_out), 32'h000);
        check("wr_b1_data", 32'(dm_wr_data_out), 32'h5A);
        tick();
        check("wr_busy", 32'(st_busy_out), 32'd0);

        // Full buffer: third request stalls and is dropped
        dm_wr_ready_in = 1'b0;
        x0 = xfers;
        drive_store(10'h100, 16'h0011, 1'b0, 1'b1);
        tick();
        drive_store(10'h101, 16'h0022, 1'b0, 1'b1);
        tick();
        check("f_stall", 32'(st_stall_out), 32'd1);
        drive_store(10'h102, 16'h0033, 1'b0, 1'b0);
        tick();
        st_valid_in = 1'b0;
        check("f_stall2", 32'(st_stall_out), 32'd1);
        check("f_head", 32'(dm_wr_addr_out), 32'h100);
        dm_wr_ready_in = 1'b1;
        tick();
        check("f_unstall", 32'(st_stall_out), 32'd0);
        check("f_b2b_en", 32'(dm_wr_en_out), 32'd1);
        check("f_b2b_addr", 32'(dm_wr_addr_out), 32'h101);
        tick();
        tick();
        tick();
        check("f_busy", 32'(st_busy_out), 32'd0);
        check("f_count", 32'(xfers - x0), 32'd2);

        // Reset while the high byte of a wide store is pending
        dm_wr_ready_in = 1'b0;
        x0 = xfers;
        drive_store(10'h200, 16'hC3D4, 1'b1, 1'b0);
        exp_q.push_back('{addr: 10'h200, data: 8'hD4});
        tick();
        st_valid_in = 1'b0;
        tick();
        dm_wr_ready_in = 1'b1;
        tick();
        check("r_in_b1", 32'(dm_wr_addr_out), 32'h201);
        dm_wr_ready_in = 1'b0;
        ld_addr_in = 10'h201; #1;
        check("r_haz_pre", 32'(ld_hazard_out), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("r_stall", 32'(st_stall_out), 32'd0);
        check("r_busy",  32'(st_busy_out),  32'd0);
        check("r_en",    32'(dm_wr_en_out), 32'd0);
        check("r_addr",  32'(dm_wr_addr_out), 32'd0);
        check("r_data",  32'(dm_wr_data_out), 32'd0);
        check("r_haz",   32'(ld_hazard_out), 32'd0);
        dm_wr_ready_in = 1'b1;
        tick(); tick(); tick();
        check("r_en_after", 32'(dm_wr_en_out), 32'd0);
        check("r_count", 32'(xfers - x0), 32'd1);
        check("q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
